interval_timer: RTL
===================

Name: interval_timer

Overview:
- Parametrised successor to the single fixed-period decisecond pulse generator.
- A prescaler divides the system clock into a base tick. A programmable interval counter counts base ticks up to a run-time period and signals expiry.
- Supports periodic and one-shot modes, retrigger, pause and synchronous clear.
- Serves the lock's entry timeout, lockout delay and display blink timing from one block type.

Parameters:
- PRESCALE, 10_000_000, clock cycles per base tick (100 MHz to 10 Hz); legal range 2 to 2**PRESC_W.
- PRESC_W, 24, prescaler counter width.
- CNT_W, 8, width of period and elapsed count.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately on assertion.
- run  in  1  enable; 0 freezes the prescaler and the interval count.
- counterReset  in  1  synchronous clear of prescaler, interval count and FSM.
- start  in  1  single-cycle launch/retrigger request.
- mode  in  1  0 = periodic, 1 = one-shot; latched at start.
- period  in  CNT_W  interval length in base ticks; latched at start.
- tick  out  1  registered 1-cycle base-tick pulse.
- expire  out  1  registered 1-cycle pulse at interval end.
- busy  out  1  high in COUNT state.
- done  out  1  high in DONE state (one-shot finished).
- elapsed  out  CNT_W  base ticks counted in the current interval.

Behaviour:
- Reset (reset=0): all of the following are 0 — prescaler, elapsed, latched period, latched mode, tick, expire, busy, done. State goes to IDLE.
- FSM states:
  - IDLE: start with period!=0 goes to COUNT. Start with period==0 is ignored and the state stays IDLE.
  - COUNT: interval end goes to COUNT if periodic, or to DONE if one-shot.
  - DONE: start with period!=0 goes to COUNT.
  - counterReset=1 in any state goes to IDLE.
- Priority: counterReset > start > run/tick progress.
- counterReset at an edge: clears prescaler and elapsed, sets state to IDLE, and forces tick and expire to 0 in the following cycle. The latched period and mode are retained.
- Start accepted (period!=0, counterReset=0):
  - Latches period and mode.
  - Prescaler goes to 0, elapsed goes to 0, state goes to COUNT.
  - Applies in every state. A start in COUNT is a retrigger: it discards any tick or expire due at that edge.
- Prescaler:
  - Increments only while run=1 and state=COUNT.
  - On reaching PRESCALE-1 it wraps to 0 and tick is set for the next cycle.
  - It holds in IDLE and DONE, so tick never pulses there.
- Interval: on each base-tick edge (prescaler wrap) in COUNT:
  - If elapsed==period-1, expire is set for the next cycle and elapsed goes to 0. In periodic mode the state stays COUNT; in one-shot mode it goes to DONE.
  - Otherwise elapsed increments.
- Latency:
  - With run held high, the first expire is high exactly period*PRESCALE cycles after the edge that accepted start.
  - In periodic mode, subsequent expires follow every period*PRESCALE cycles.
- run=0: prescaler and elapsed hold; tick and expire are 0. Resuming run continues the count with no lost cycles. Total latency = period*PRESCALE plus the cycles spent paused.
- Width rules:
  - elapsed never exceeds period-1.
  - All compares are unsigned.
  - period = 2**CNT_W-1 is legal.
- One-shot DONE: done stays high until start or counterReset. elapsed reads 0 in DONE.
- Period or mode changes on the inputs between starts have no effect.
- Asynchronous reset mid-interval: all outputs drop to 0 without waiting for a clock edge. Counting resumes only after reset is released and a new start is accepted.

Test Plan:
- PRESCALE=4, CNT_W=4, run=1:
  - mode=0, period=3, pulse start at cycle 0 -> tick at cycles 4, 8, 12, 16...; expire at cycles 12, 24, 36; busy stays 1; elapsed runs 0,1,2,0...
  - mode=1, period=2, start -> expire at cycle 8, then done=1 and busy=0. No tick after cycle 8. A new start with period=1 -> expire 4 cycles later.
  - Period=3 start; drop run for 5 cycles at cycle 6 -> expire at cycle 17. Prescaler and elapsed values are unchanged across the pause.
  - start and counterReset high at the same edge mid-interval -> state IDLE, elapsed=0, no expire. A start with period=0 in IDLE -> busy stays 0.
  - Retrigger at cycle 10 of a period=3 interval -> no expire at cycle 12; next expire at cycle 22.
  - Assert reset asynchronously between edges during COUNT -> busy, done and elapsed read 0 before the next clock edge. After release, there is no activity until start.

Source files
------------

// File: rtl/interval_timer_if.sv
// Control and status bundle between an interval timer and its user.
// The timer sits on the slave side; the user logic or a bench drives the master side.
interface interval_timer_if #(
   parameter int CNT_W = 8
);
   logic             run;
   logic             counterReset;
   logic             start;
   logic             mode;
   logic [CNT_W-1:0] period;
   logic             tick;
   logic             expire;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] elapsed;

   modport master (
      output run, counterReset, start, mode, period,
      input  tick, expire, busy, done, elapsed
   );

   modport slave (
      input  run, counterReset, start, mode, period,
      output tick, expire, busy, done, elapsed
   );
endinterface

// File: rtl/interval_timer.sv
// Prescaled interval timer with periodic and one-shot modes.
// It also supports retrigger, pause via run, and a synchronous clear.
module interval_timer #(
   parameter int PRESCALE = 10_000_000,
   parameter int PRESC_W  = 24,
   parameter int CNT_W    = 8
) (
   input logic          clock,
   input logic          reset,
   interval_timer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

   state_t             state_q;
   state_t             state_d;
   logic [PRESC_W-1:0] presc_q;
   logic [CNT_W-1:0]   elapsed_q;
   logic [CNT_W-1:0]   period_q;
   logic               mode_q;
   logic               tick_q;
   logic               expire_q;
   logic               busy_c;
   logic               done_c;

   logic start_ok;
   logic wrap;
   logic interval_end;

   assign start_ok     = bus.start && (bus.period != '0);
   assign wrap         = (state_q == COUNT) && bus.run && (presc_q == PRESC_MAX);
   assign interval_end = wrap && (elapsed_q == (period_q - CNT_W'(1)));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.counterReset) begin
         state_d = IDLE;
      end else if (start_ok) begin
         state_d = COUNT;
      end else if (interval_end && mode_q) begin
         state_d = DONE;
      end
   end

   always_comb begin
      busy_c = (state_q == COUNT);
      done_c = (state_q == DONE);
   end

   // Clear beats start, and start beats tick progress, so a retrigger drops any pulse due at that edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc_q   <= '0;
         elapsed_q <= '0;
         period_q  <= '0;
         mode_q    <= 1'b0;
         tick_q    <= 1'b0;
         expire_q  <= 1'b0;
      end else if (bus.counterReset) begin
         presc_q   <= '0;
         elapsed_q <= '0;
         tick_q    <= 1'b0;
         expire_q  <= 1'b0;
      end else if (start_ok) begin
         presc_q   <= '0;
         elapsed_q <= '0;
         period_q  <= bus.period;
         mode_q    <= bus.mode;
         tick_q    <= 1'b0;
         expire_q  <= 1'b0;
      end else if ((state_q == COUNT) && bus.run) begin
         tick_q   <= wrap;
         expire_q <= interval_end;
         if (wrap) begin
            presc_q <= '0;
            if (interval_end) begin
               elapsed_q <= '0;
            end else begin
               elapsed_q <= elapsed_q + CNT_W'(1);
            end
         end else begin
            presc_q <= presc_q + PRESC_W'(1);
         end
      end else begin
         tick_q   <= 1'b0;
         expire_q <= 1'b0;
      end
   end

   assign bus.tick    = tick_q;
   assign bus.expire  = expire_q;
   assign bus.busy    = busy_c;
   assign bus.done    = done_c;
   assign bus.elapsed = elapsed_q;

endmodule
